register_fifo: RTL
==================

REGISTER_FIFO -- requirements
Module: register_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (32 matches register_t).
REQ-002 SHALL have parameter DEPTH, default 16, storage depth in words; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, the count at which almost_full asserts; range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-007 SHALL have port write, input, 1 bit: push data_in this cycle.
REQ-008 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port read, input, 1 bit: pop the head word this cycle.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits: head word, first-word-fall-through.
REQ-011 SHALL have ports empty, full and almost_full, each an output of 1 bit, reporting status.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of words held, 0..DEPTH.
REQ-013 SHALL have ports overflow and underflow, each an output of 1 bit: sticky error flags.

Function
REQ-014 SHALL implement storage as a DEPTH x DATA_WIDTH array with rd_ptr and wr_ptr of $clog2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write when write=1 and (full=0 or read=1): store data_in at wr_ptr and advance wr_ptr at the clock edge.
REQ-016 SHALL accept a read when read=1 and empty=0: advance rd_ptr at the clock edge.
REQ-017 SHALL present data_out = mem[rd_ptr] whenever empty=0, and all-zeros whenever empty=1; a written word appears on data_out the cycle after its write.
REQ-018 SHALL update count as count+1 (write only), count-1 (read only), or unchanged (both accepted, or neither).
REQ-019 SHALL derive empty = (count==0), full = (count==DEPTH) and almost_full = (count>=AFULL_LEVEL) from registered count, with no combinational path from write or read.
REQ-020 SHALL, on full with write=1 and read=0, discard data_in, leave state unchanged and set overflow=1.
REQ-021 SHALL, on empty with read=1, ignore the read and set underflow=1; any simultaneous write is still accepted.
REQ-022 SHALL, on full with both write and read asserted, accept both: the head is popped, data_in is stored and count stays at DEPTH.
REQ-023 SHALL hold overflow and underflow at 1 until clear or reset.
REQ-024 SHALL, when clear=1, take priority over write and read in the same cycle: zero both pointers, count, overflow and underflow; memory contents need not be cleared.

Reset
REQ-025 SHALL, while reset=0 and regardless of clk, force rd_ptr=0, wr_ptr=0, count=0, overflow=0, underflow=0, and hence empty=1, full=0, almost_full=0, data_out=0.
REQ-026 SHALL discard in-flight words when reset asserts mid-operation, and SHALL resume normal operation on the first rising clk edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro REGISTER_FIFO_STATS_EN defined, add output high_water ($clog2(DEPTH)+1 bits) holding the maximum count reached since reset or clear; it updates on the cycle count rises above it and resets/clears to 0.
REQ-028 SHALL, without REGISTER_FIFO_STATS_EN, omit the high_water port and its logic entirely, with no other behavioural change.

Verification (DEPTH=4, AFULL_LEVEL=3, DATA_WIDTH=32)
REQ-029 SHALL cover: write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full at 4; data_out=0x11 from the cycle after the first write.
REQ-030 SHALL cover: on full, write 0x55 with read=0 -> count stays 4, overflow=1; four reads return 0x11,0x22,0x33,0x44, then empty=1 and data_out=0.
REQ-031 SHALL cover: on full, read=1 and write=0x66 in one cycle -> count stays 4, head becomes 0x22, and 0x66 is read last (pointer wrap exercised).
REQ-032 SHALL cover: on empty, read=1 and write=0x77 in one cycle -> underflow=1, count=1, data_out=0x77 next cycle.
REQ-033 SHALL cover: with 3 words held, assert clear together with write -> next cycle count=0, empty=1, flags 0, high_water=0 (STATS_EN build).
REQ-034 SHALL cover: assert reset asynchronously mid-burst between clock edges -> outputs reach reset values immediately; after release, write 0xAA -> data_out=0xAA next cycle.

Source files
------------

// File: rtl/register_fifo.sv
// Synchronous FWFT register FIFO with sticky overflow/underflow flags; REGISTER_FIFO_STATS_EN adds a high_water output.
// Latency: a written word is on data_out the cycle after its write; status outputs are decoded from the registered count.
// Backpressure: writes are refused while full unless a read pops in the same cycle (sets overflow); reads while empty set underflow.
module register_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
`ifdef REGISTER_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]  high_water
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // A pop while full frees the slot the simultaneous push lands in.
    assign wr_acc = write && (!full || read);
    assign rd_acc = read && !empty;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);
    assign almost_full = (count >= AFULL_CNT);
    assign data_out    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (write && full && !read) begin
                overflow <= 1'b1;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; pointers and count alone define what is visible.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef REGISTER_FIFO_STATS_EN
    // Tracks count_next so the mark moves on the same edge as count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_water <= '0;
        end else if (clear) begin
            high_water <= '0;
        end else if (count_next > high_water) begin
            high_water <= count_next;
        end
    end
`endif

endmodule
